maze_mem_arbiter: RTL
=====================

Name: maze_mem_arbiter

Overview:
- Shares the single-port maze cell memory between two requesters: the maze solver controller (visited-mark RD/WR) and the host port (maze load before start, readback of visited marks after Done).
- Sits between both requesters and the memory macro.
- The solver has priority by default; a starvation counter guarantees the host progress.
- A lock lets the host own the memory for a whole load burst.

Parameters:
- ADDR_W, 8, cell address width ({y[3:0], x[3:0]} for a 16x16 maze).
- STARVE_MAX, 4, consecutive denied host-request cycles after which the host wins the next arbitration.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- s_req  input  1  solver access request; held until granted.
- s_we  input  1  solver write (1) / read (0).
- s_addr  input  ADDR_W  solver cell address.
- s_wdata  input  1  solver write data (visited mark).
- s_gnt  output  1  solver granted this cycle; the access is issued to memory this cycle.
- s_rvalid  output  1  solver read data valid (cycle after the read grant).
- s_rdata  output  1  solver read data.
- h_req, h_we, h_addr, h_wdata  input  1/1/ADDR_W/1  host request fields; same rules as the solver.
- h_lock  input  1  host requests exclusive ownership.
- h_gnt, h_rvalid, h_rdata  output  1/1/1  host grant / read valid / read data.
- m_en  output  1  memory access strobe.
- m_we  output  1  memory write enable.
- m_addr  output  ADDR_W  memory address.
- m_wdata  output  1  memory write data.
- m_rdata  input  1  memory read data, valid 1 cycle after m_en with m_we=0.
- locked  output  1  arbiter is in the LOCKED state.

Behaviour:
- Reset (rst=1 at an edge): state=SHARED, starve_cnt=0, pending-read tags cleared. The combinational outputs are 0 during reset: s_gnt, h_gnt, m_en, m_we. The registered outputs are 0 after reset: s_rvalid, h_rvalid, locked. An in-flight read is dropped (no rvalid).
- Grants are combinational from the current state, starve_cnt and the req inputs. At most one grant per cycle.
- On a grant, m_en=1 and m_we/m_addr/m_wdata mux from the winner in the same cycle. With no grant, m_en=0, m_we=0, and m_addr/m_wdata are 0.
- Read latency:
  - A read granted in cycle N gives {owner}_rvalid=1 in cycle N+1 only, with {owner}_rdata=m_rdata.
  - rdata outputs are 0 when the matching rvalid is 0.
  - Writes produce no rvalid.
- Requester contract:
  - req, we, addr and wdata stay stable until gnt.
  - req may drop or re-assert the cycle after gnt.
  - Back-to-back grants to the same requester are allowed.
- State SHARED:
  - Only s_req: grant solver.
  - Only h_req: grant host.
  - Both, starve_cnt < STARVE_MAX: grant solver, starve_cnt+1.
  - Both, starve_cnt == STARVE_MAX: grant host, starve_cnt<=0.
  - Any host grant clears starve_cnt. A cycle with h_req=0 clears starve_cnt. starve_cnt saturates, never wraps; width is clog2(STARVE_MAX+1).
  - Transition to LOCKED when h_lock=1 in a cycle where the host is granted. Set locked=1 next cycle.
- State LOCKED:
  - Host granted whenever h_req=1; solver never granted; s_req waits.
  - starve_cnt held at 0.
  - When h_lock=0 and h_req=0, return to SHARED next cycle and drop locked.
  - Dropping h_lock while h_req=1 stays LOCKED until h_req also falls.
- h_lock while in SHARED without a host grant has no effect until the host wins arbitration.
- Simultaneous events:
  - A read grant in cycle N and a new grant in N+1 coexist: rvalid for N and m_en for N+1 are in the same cycle.
  - rvalid follows the tagged owner, not the current winner.
- rst asserted mid-lock: returns to SHARED; the host must re-assert h_lock.

Decomposition:
- Shared package maze_mem_pkg: ADDR_W and the state encoding constants (SHARED=1'b0, LOCKED=1'b1), reusable by the memory and the host loader.
- One sub-module, maze_starve_counter: saturating counter with inc/clr/at_max.
- The grant mux, read tags and FSM stay in maze_mem_arbiter.

Test Plan:
- Solver-only read of addr 8'h23 holding value 1: s_gnt same cycle, m_en=1, m_we=0, m_addr=8'h23; next cycle s_rvalid=1, s_rdata=1, h_rvalid=0.
- Both requesting continuously, STARVE_MAX=4: grants S,S,S,S,H,S,S,S,S,H repeat; the host never waits more than 5 cycles.
- Host lock burst: h_lock=1 and h_req with 10 writes while s_req=1. Expect 10 consecutive h_gnt, s_gnt=0 throughout, and locked=1 from the cycle after the first h_gnt. After h_lock=0 and h_req=0, locked=0 and s_gnt on the following cycle.
- Back-to-back: host read in cycle N, solver write in N+1. Expect h_rvalid=1 and solver m_en/m_we=1 in the same cycle N+1, and no s_rvalid.
- rst=1 in the cycle after a solver read grant: s_rvalid stays 0, locked=0, starve_cnt=0; the next solver request is granted normally.
- h_lock asserted while the solver wins (starve_cnt<4): no lock until the host is granted; locked rises the cycle after that h_gnt.

Source files
------------

// File: rtl/maze_mem_pkg.sv
// Shared constants for the maze cell memory path: address width, starvation limit, arbiter states.
package maze_mem_pkg;

  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned STARVE_MAX = 4;

  typedef enum logic {
    SHARED = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/maze_starve_counter.sv
// Saturating count of consecutive cycles the host was denied; at_max is registered.
module maze_starve_counter #(
  parameter int unsigned MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int unsigned CNT_W = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // Clear wins over increment; the count holds once it reaches MAX.
  always_comb begin
    cnt_next = cnt;
    if (clr) begin
      cnt_next = '0;
    end else if (inc && (cnt != CNT_W'(MAX))) begin
      cnt_next = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      at_max <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      at_max <= (cnt_next == CNT_W'(MAX));
    end
  end

endmodule

// File: rtl/maze_mem_arbiter.sv
// Arbitrates the single-port maze cell memory between the solver and the host,
// with host starvation protection and an exclusive host lock for load bursts.
module maze_mem_arbiter
  import maze_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = maze_mem_pkg::ADDR_W,
  parameter int unsigned STARVE_MAX = maze_mem_pkg::STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_req,
  input  logic              s_we,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic              s_wdata,
  output logic              s_gnt,
  output logic              s_rvalid,
  output logic              s_rdata,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic              h_wdata,
  input  logic              h_lock,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic              h_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_wdata,
  input  logic              m_rdata,
  output logic              locked
);

  arb_state_e state;
  arb_state_e state_next;
  logic       s_win;
  logic       h_win;
  logic       cnt_inc;
  logic       cnt_clr;
  logic       at_max;
  logic       s_pend;
  logic       h_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SHARED;
    end else begin
      state <= state_next;
    end
  end

  // Grant decision and next state; grants are forced low while in reset.
  always_comb begin
    state_next = state;
    s_win      = 1'b0;
    h_win      = 1'b0;
    case (state)
      SHARED: begin
        if (h_req && (!s_req || at_max)) begin
          h_win = 1'b1;
        end else if (s_req) begin
          s_win = 1'b1;
        end
        if (h_win && h_lock) begin
          state_next = LOCKED;
        end
      end
      LOCKED: begin
        h_win = h_req;
        if (!h_lock && !h_req) begin
          state_next = SHARED;
        end
      end
      default: state_next = SHARED;
    endcase
    if (rst) begin
      s_win = 1'b0;
      h_win = 1'b0;
    end
  end

  // Count only cycles where the host asked and the solver won in shared mode.
  assign cnt_inc = (state == SHARED) && s_win && h_req;
  assign cnt_clr = !h_req || h_win || (state == LOCKED);

  maze_starve_counter #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (cnt_inc),
    .clr    (cnt_clr),
    .at_max (at_max)
  );

  assign s_gnt   = s_win;
  assign h_gnt   = h_win;
  assign m_en    = s_win | h_win;
  assign m_we    = s_win ? s_we    : (h_win ? h_we    : 1'b0);
  assign m_addr  = s_win ? s_addr  : (h_win ? h_addr  : '0);
  assign m_wdata = s_win ? s_wdata : (h_win ? h_wdata : 1'b0);

  // Read tags remember who owns the data returning next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_pend <= 1'b0;
      h_pend <= 1'b0;
      locked <= 1'b0;
    end else begin
      s_pend <= s_win && !s_we;
      h_pend <= h_win && !h_we;
      locked <= (state_next == LOCKED);
    end
  end

  // A reset arriving while a read is in flight drops its return.
  assign s_rvalid = s_pend & ~rst;
  assign h_rvalid = h_pend & ~rst;
  assign s_rdata  = s_rvalid & m_rdata;
  assign h_rdata  = h_rvalid & m_rdata;

endmodule
